// File: rtl/control_sequencer.sv
// Fixed-cycle microsequencer for the 8-bit accumulator CPU. A T-state counter
// walks fetch (T0-T2) and execute (T3-T5), and the current opcode decodes into strobes.
module control_sequencer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [7:0] INSTR,
    output logic       OPC,
    output logic       IPC_INC,
    output logic       IMAR,
    output logic       ORAM,
    output logic       IRAM,
    output logic       IIR,
    output logic       OIR,
    output logic       IACC,
    output logic       OACC,
    output logic       IB,
    output logic       OALU,
    output logic       ALU_SUB,
    output logic       IOUT,
    output logic [2:0] T_STATE,
    output logic       HALTED
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } t_state_e;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    t_state_e   state_reg;
    t_state_e   state_next;
    logic       halted_reg;
    logic       halted_next;
    logic [3:0] opcode;
    logic       operand_unused;

    assign opcode  = INSTR[7:4];
    // The operand nibble travels over the bus via OIR; the sequencer never decodes it.
    assign operand_unused = ^INSTR[3:0];

    assign T_STATE = state_reg;
    assign HALTED  = halted_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= T0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= halted_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        halted_next = halted_reg;
        OPC         = 1'b0;
        IPC_INC     = 1'b0;
        IMAR        = 1'b0;
        ORAM        = 1'b0;
        IRAM        = 1'b0;
        IIR         = 1'b0;
        OIR         = 1'b0;
        IACC        = 1'b0;
        OACC        = 1'b0;
        IB          = 1'b0;
        OALU        = 1'b0;
        ALU_SUB     = 1'b0;
        IOUT        = 1'b0;

        // Reset, disable and halt all freeze the decode; the register block handles reset.
        if (!RST && EN && !halted_reg) begin
            case (state_reg)
                T0: begin
                    OPC        = 1'b1;
                    IMAR       = 1'b1;
                    state_next = T1;
                end
                T1: begin
                    IPC_INC    = 1'b1;
                    state_next = T2;
                end
                T2: begin
                    ORAM       = 1'b1;
                    IIR        = 1'b1;
                    state_next = T3;
                end
                T3: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            OIR        = 1'b1;
                            IMAR       = 1'b1;
                            state_next = T4;
                        end
                        OP_OUT: begin
                            OACC       = 1'b1;
                            IOUT       = 1'b1;
                            state_next = T0;
                        end
                        OP_HLT: begin
                            halted_next = 1'b1;
                            state_next  = T3;
                        end
                        default: state_next = T0;
                    endcase
                end
                T4: begin
                    state_next = T0;
                    case (opcode)
                        OP_LDA: begin
                            ORAM = 1'b1;
                            IACC = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ORAM       = 1'b1;
                            IB         = 1'b1;
                            ALU_SUB    = (opcode == OP_SUB);
                            state_next = T5;
                        end
                        OP_STA: begin
                            OACC = 1'b1;
                            IRAM = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    state_next = T0;
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        OALU    = 1'b1;
                        IACC    = 1'b1;
                        ALU_SUB = (opcode == OP_SUB);
                    end
                end
                // Encodings 6 and 7 recover to T0 with no strobes.
                default: state_next = T0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer: per-cycle vectors of inputs and the expected
// T-state, strobes and HALTED, plus halt/reset and randomized bus-driver sequences.
module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] instr;
    logic       opc, ipc_inc, imar, oram, iram, iir, oir;
    logic       iacc, oacc, ib, oalu, alu_sub, iout;
    logic [2:0] t_state;
    logic       halted;

    control_sequencer dut (
        .CLK     (clk),
        .RST     (rst),
        .EN      (en),
        .INSTR   (instr),
        .OPC     (opc),
        .IPC_INC (ipc_inc),
        .IMAR    (imar),
        .ORAM    (oram),
        .IRAM    (iram),
        .IIR     (iir),
        .OIR     (oir),
        .IACC    (iacc),
        .OACC    (oacc),
        .IB      (ib),
        .OALU    (oalu),
        .ALU_SUB (alu_sub),
        .IOUT    (iout),
        .T_STATE (t_state),
        .HALTED  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector bit positions, MSB first.
    localparam logic [12:0] S_OPC  = 13'h1000;
    localparam logic [12:0] S_INC  = 13'h0800;
    localparam logic [12:0] S_IMAR = 13'h0400;
    localparam logic [12:0] S_ORAM = 13'h0200;
    localparam logic [12:0] S_IRAM = 13'h0100;
    localparam logic [12:0] S_IIR  = 13'h0080;
    localparam logic [12:0] S_OIR  = 13'h0040;
    localparam logic [12:0] S_IACC = 13'h0020;
    localparam logic [12:0] S_OACC = 13'h0010;
    localparam logic [12:0] S_IB   = 13'h0008;
    localparam logic [12:0] S_OALU = 13'h0004;
    localparam logic [12:0] S_SUB  = 13'h0002;
    localparam logic [12:0] S_IOUT = 13'h0001;
    localparam logic [12:0] S_NONE = 13'h0000;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  instr;
        logic [2:0]  exp_state;
        logic [12:0] exp_strobes;
        logic        exp_halted;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [12:0] strobes;
    logic [4:0]  drivers;
    assign strobes = {opc, ipc_inc, imar, oram, iram, iir, oir, iacc, oacc, ib, oalu, alu_sub, iout};
    assign drivers = {opc, oram, oir, oacc, oalu};

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] ins,
                                input logic [2:0] st, input logic [12:0] sb, input logic h);
        vec_t v;
        v.rst = r; v.en = e; v.instr = ins;
        v.exp_state = st; v.exp_strobes = sb; v.exp_halted = h;
        return v;
    endfunction

    task automatic push_fetch(input logic [7:0] ins);
        tbl.push_back(mk(1'b0, 1'b1, ins, 3'd0, S_OPC | S_IMAR, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, ins, 3'd1, S_INC, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, ins, 3'd2, S_ORAM | S_IIR, 1'b0));
    endtask

    // Drive one cycle's inputs after the falling edge, then check the outputs before the rising edge.
    task automatic run_row(input vec_t v, input string tag, input int idx, input bit chk_state);
        @(negedge clk);
        rst   = v.rst;
        en    = v.en;
        instr = v.instr;
        #1;
        if (chk_state) begin
            n_cmp++;
            if (t_state !== v.exp_state) begin
                n_bad++;
                $display("FAIL %s[%0d] t_state: got %0d want %0d", tag, idx, t_state, v.exp_state);
            end
            n_cmp++;
            if (halted !== v.exp_halted) begin
                n_bad++;
                $display("FAIL %s[%0d] halted: got %0b want %0b", tag, idx, halted, v.exp_halted);
            end
        end
        n_cmp++;
        if (strobes !== v.exp_strobes) begin
            n_bad++;
            $display("FAIL %s[%0d] strobes: got %013b want %013b", tag, idx, strobes, v.exp_strobes);
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        instr = 8'h00;

        // Reset cycle: state is unknown before the edge, strobes must already be low.
        run_row(mk(1'b1, 1'b1, 8'h1A, 3'd0, S_NONE, 1'b0), "reset", 0, 1'b0);

        // LDA 0x1A
        push_fetch(8'h1A);
        tbl.push_back(mk(1'b0, 1'b1, 8'h1A, 3'd3, S_OIR | S_IMAR, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h1A, 3'd4, S_ORAM | S_IACC, 1'b0));
        // SUB 0x3C
        push_fetch(8'h3C);
        tbl.push_back(mk(1'b0, 1'b1, 8'h3C, 3'd3, S_OIR | S_IMAR, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h3C, 3'd4, S_ORAM | S_IB | S_SUB, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h3C, 3'd5, S_OALU | S_IACC | S_SUB, 1'b0));
        // OUT 0x50
        push_fetch(8'h50);
        tbl.push_back(mk(1'b0, 1'b1, 8'h50, 3'd3, S_OACC | S_IOUT, 1'b0));
        // NOP 0x00
        push_fetch(8'h00);
        tbl.push_back(mk(1'b0, 1'b1, 8'h00, 3'd3, S_NONE, 1'b0));
        // STA 0x4E
        push_fetch(8'h4E);
        tbl.push_back(mk(1'b0, 1'b1, 8'h4E, 3'd3, S_OIR | S_IMAR, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h4E, 3'd4, S_OACC | S_IRAM, 1'b0));
        // ADD 0x2F with EN low for three cycles in T4
        push_fetch(8'h2F);
        tbl.push_back(mk(1'b0, 1'b1, 8'h2F, 3'd3, S_OIR | S_IMAR, 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b0, 8'h2F, 3'd4, S_NONE, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h2F, 3'd4, S_ORAM | S_IB, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h2F, 3'd5, S_OALU | S_IACC, 1'b0));
        // Opcode 0x7 behaves as NOP
        push_fetch(8'h73);
        tbl.push_back(mk(1'b0, 1'b1, 8'h73, 3'd3, S_NONE, 1'b0));
        // ADD 0x21 aborted by reset in T5
        push_fetch(8'h21);
        tbl.push_back(mk(1'b0, 1'b1, 8'h21, 3'd3, S_OIR | S_IMAR, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h21, 3'd4, S_ORAM | S_IB, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 8'h21, 3'd5, S_NONE, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h20, 3'd0, S_OPC | S_IMAR, 1'b0));
        // EN low from T1: frozen, then resumes in T1
        tbl.push_back(mk(1'b0, 1'b0, 8'h20, 3'd1, S_NONE, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 8'h20, 3'd1, S_INC, 1'b0));

        for (int i = 0; i < tbl.size(); i++)
            run_row(tbl[i], "table", i, 1'b1);

        // HLT: reset, fetch 0xF0, T3 sets HALTED, then frozen at T3 until reset.
        run_row(mk(1'b1, 1'b1, 8'hF0, 3'd2, S_NONE, 1'b0), "hlt", 0, 1'b0);
        run_row(mk(1'b0, 1'b1, 8'hF0, 3'd0, S_OPC | S_IMAR, 1'b0), "hlt", 1, 1'b1);
        run_row(mk(1'b0, 1'b1, 8'hF0, 3'd1, S_INC, 1'b0), "hlt", 2, 1'b1);
        run_row(mk(1'b0, 1'b1, 8'hF0, 3'd2, S_ORAM | S_IIR, 1'b0), "hlt", 3, 1'b1);
        run_row(mk(1'b0, 1'b1, 8'hF0, 3'd3, S_NONE, 1'b0), "hlt", 4, 1'b1);
        for (int i = 0; i < 20; i++)
            run_row(mk(1'b0, 1'b1, 8'hF0, 3'd3, S_NONE, 1'b1), "halted", i, 1'b1);
        run_row(mk(1'b1, 1'b1, 8'hF0, 3'd3, S_NONE, 1'b1), "hlt_rst", 0, 1'b1);
        run_row(mk(1'b0, 1'b0, 8'h00, 3'd0, S_NONE, 1'b0), "hlt_rst", 1, 1'b1);

        // Randomized opcodes and EN: at most one bus driver in every cycle.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = halted;
            en  = ($urandom_range(0, 7) != 0);
            if (t_state == 3'd0)
                instr = 8'($urandom_range(0, 255));
            #1;
            n_cmp++;
            if ($countones(drivers) > 1) begin
                n_bad++;
                $display("FAIL bus_onehot[%0d]: got drivers=%05b want at most one set", i, drivers);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
